// File: rtl/ibex_fetch_fifo_param.sv
// Fetch FIFO with parametrised depth: buffers word-aligned fetches and hands out
// realigned 16/32-bit instructions with their PC, occupancy and sticky overflow.
module ibex_fetch_fifo_param #(
  parameter int NUM_REQS     = 2,
  parameter bit CompressedEn = 1'b1,
  parameter bit ResetAll     = 1'b0,
  localparam int DEPTH       = NUM_REQS + 1,
  localparam int LW          = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  output logic [NUM_REQS-1:0] busy_o,
  output logic [LW-1:0]       level_o,
  output logic                overflow_o,
  input  logic                in_valid_i,
  input  logic [31:0]         in_addr_i,
  input  logic [31:0]         in_rdata_i,
  input  logic                in_err_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_addr_o,
  output logic [31:0]         out_rdata_o,
  output logic                out_err_o,
  output logic                out_err_plus2_o,
  output logic                out_compressed_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] err_q, err_d;
  logic [31:0]      rdata_q [DEPTH];
  logic [31:0]      rdata_d [DEPTH];
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [31:1]      addr_q, addr_d;

  logic        head_valid, head_err, second_valid, second_err;
  logic [31:0] head_rdata;
  logic [15:0] second_lo;
  logic        unaligned, aligned_comp, upper_comp;
  logic        accept, pop, push, placed;
  logic        unused_addr0;

  assign unused_addr0 = in_addr_i[0];

  // Entry 0 falls back to the incoming response so an empty FIFO adds no latency.
  assign head_valid   = valid_q[0] | in_valid_i;
  assign head_rdata   = valid_q[0] ? rdata_q[0] : in_rdata_i;
  assign head_err     = valid_q[0] ? err_q[0] : in_err_i;
  assign second_valid = valid_q[1] | (valid_q[0] & in_valid_i);
  assign second_lo    = valid_q[1] ? rdata_q[1][15:0] : in_rdata_i[15:0];
  assign second_err   = valid_q[1] ? err_q[1] : in_err_i;

  assign unaligned    = CompressedEn && addr_q[1];
  assign aligned_comp = CompressedEn && (head_rdata[1:0] != 2'b11) && !head_err;
  assign upper_comp   = CompressedEn && (head_rdata[17:16] != 2'b11) && !head_err;

  always_comb begin
    out_valid_o      = head_valid;
    out_rdata_o      = head_rdata;
    out_err_o        = head_err;
    out_err_plus2_o  = 1'b0;
    out_compressed_o = aligned_comp;
    if (unaligned) begin
      out_rdata_o = {second_lo, head_rdata[31:16]};
      if (upper_comp) begin
        out_compressed_o = 1'b1;
      end else begin
        out_valid_o      = second_valid;
        out_err_o        = head_err | second_err;
        out_err_plus2_o  = second_err & ~head_err;
        out_compressed_o = 1'b0;
      end
    end
  end

  assign out_addr_o = {addr_q, 1'b0};
  assign accept     = out_valid_o & out_ready_i;
  // An aligned compressed instruction only consumes half the head word.
  assign pop        = accept & (unaligned | ~out_compressed_o);
  assign push       = in_valid_i & ~valid_q[DEPTH-1];

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    placed  = 1'b0;
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!valid_d[i] && !placed) begin
          valid_d[i] = 1'b1;
          err_d[i]   = in_err_i;
          rdata_d[i] = in_rdata_i;
          placed     = 1'b1;
        end
      end
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        valid_d[i] = valid_d[i+1];
        err_d[i]   = err_d[i+1];
        rdata_d[i] = rdata_d[i+1];
      end
      valid_d[DEPTH-1] = 1'b0;
    end
    if (clear_i) begin
      valid_d = '0;
    end
  end

  always_comb begin
    level_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      level_d = level_d + LW'(valid_d[i]);
    end
  end

  assign overflow_d = clear_i ? 1'b0 : (overflow_q | (in_valid_i & valid_q[DEPTH-1]));

  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = {in_addr_i[31:2], in_addr_i[1] & CompressedEn};
    end else if (accept) begin
      addr_d = addr_q + (out_compressed_o ? 31'd1 : 31'd2);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Without ResetAll the datapath simply holds its value through reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      if (ResetAll) begin
        addr_q <= '0;
        err_q  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          rdata_q[i] <= '0;
        end
      end
    end else begin
      addr_q  <= addr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o     = valid_q[DEPTH-1:1];
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/ibex_fetch_fifo_param.md
# ibex_fetch_fifo_param

Parametrised fetch FIFO for the Ibex prefetch path. It buffers word-aligned 32-bit instruction fetches and realigns them into whole 16/32-bit instructions with their PCs. It sits between the instruction bus response path and the IF stage. It succeeds the fixed 3-entry fetch FIFO with:
- arbitrary depth;
- an optional compressed-ISA mode;
- an occupancy count;
- sticky overflow detection.

## Interface
Parameters:
- NUM_REQS, default 2: maximum outstanding bus requests. Legal range 1..8. Storage depth is DEPTH = NUM_REQS+1.
- CompressedEn, default 1: when 0, every instruction is treated as 32-bit and aligned, and the unaligned path is removed.
- ResetAll, default 0: when 1, the address register and data/err storage are also reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low, sampled on the rising edge of clk_i
- clear_i  in  1  flush contents; load new PC from in_addr_i
- busy_o  out  NUM_REQS  valid flags of entries DEPTH-1 down to DEPTH-NUM_REQS
- level_o  out  $clog2(DEPTH+1)  number of valid stored words
- overflow_o  out  1  sticky flag: a push was attempted while full
- in_valid_i  in  1  fetch response valid
- in_addr_i  in  32  new PC; used only with clear_i; bit 0 ignored
- in_rdata_i  in  32  fetched word
- in_err_i  in  1  bus error for the fetched word
- out_valid_o  out  1  instruction available
- out_ready_i  in  1  consumer accepts the instruction
- out_addr_o  out  32  PC of the output instruction; bit 0 is always 0
- out_rdata_o  out  32  instruction; upper half is don't-care if compressed
- out_err_o  out  1  fetch error on the instruction
- out_err_plus2_o  out  1  error comes from the second halfword of an unaligned 32-bit instruction
- out_compressed_o  out  1  output instruction is 16-bit (always 0 when CompressedEn=0)

## Operation
Storage:
- DEPTH entries of {rdata[31:0], err, valid}. Entry 0 is the head.
- Pushes go to the lowest invalid entry. Pop shifts every entry down by one.
- Push and pop in the same cycle: the incoming word lands in the slot vacated by the shift.

Head word:
- valid_q[0] ? entry0 : in_* (combinational bypass).
- valid = valid_q[0] | in_valid_i.

Second word:
- valid_q[1] ? entry1 : in_*.

Compressed detection:
- A halfword is compressed when bits [1:0] != 2'b11, head err = 0, and CompressedEn = 1.

Aligned PC (addr[1]=0):
- Output the head word; out_err_plus2_o = 0.
- out_valid_o = valid.

Unaligned PC (addr[1]=1):
- Data: {second[15:0], head[31:16]}.
- If the upper halfword is compressed, out_valid_o = valid and the error is the head error.
- Otherwise out_valid_o requires both words.
  - out_err_o = head err | second err.
  - out_err_plus2_o = second err & ~head err.

Pop condition:
- Pop when out_valid_o & out_ready_i and either (aligned and not compressed) or unaligned.
- An aligned compressed instruction leaves the word in place.

PC register (31 bits, [31:1]):
- On clear_i: loads in_addr_i[31:1].
- Otherwise, on accept: advances by 2 if compressed, else by 4. Wraps modulo 2^32.
- When CompressedEn=0, the PC always advances by 4 and addr[1] is treated as 0.

clear_i:
- Next cycle has all valid = 0 and level 0. A same-cycle push or pop is discarded.
- Clears overflow_o.

Level and overflow:
- level_o = popcount of valid_q. It is registered and updated with valid_q.
- A push with valid_q[DEPTH-1]=1 and no clear is dropped, with no effect on storage, and sets overflow_o. This holds even if a simultaneous pop occurs.

Synchronous reset (rst_ni=0 at an edge):
- valid=0, level_o=0, busy_o=0, overflow_o=0.
- The PC is reset to 0 only if ResetAll=1.
- Reset overrides clear_i and pushes in the same cycle.

## Timing
- Bypass latency: 0 cycles. in_valid_i into an empty FIFO with an aligned PC gives out_valid_o in the same cycle.
- Stored latency: a pushed word is visible as head or second on the next cycle.
- Registered outputs: busy_o, level_o, and overflow_o reflect the state after the last edge and have no combinational path from inputs.
- Combinational outputs: out_* depend combinationally on in_* and out_ready_i only through the bypass.
- out_valid_o may drop without acceptance only on clear_i.
- After reset: out_valid_o = in_valid_i & (aligned or compressed-upper).
- Full: valid_q[DEPTH-1]=1. Empty: valid_q[0]=0.

## Test plan
- Aligned bypass stream.
  - Stimulus: reset; clear with in_addr_i=0x80; push 0x00000013 while ready=1.
  - Required: same-cycle out_valid_o=1, out_addr_o=0x80, level_o stays 0; next out_addr_o=0x84.
- Compressed split.
  - Stimulus: clear to 0x100; push 0x4501_4505 then 0x0013_0001; ready=1.
  - Required: instructions at 0x100 (16-bit), 0x102 (16-bit), 0x104 (16-bit).
  - Required: first pop occurs after 0x102 is accepted.
- Unaligned 32-bit.
  - Stimulus: clear to 0x202; push 0x0513_xxxx; ready=1.
  - Required: out_valid_o=0 until the second word 0xxxxx_0000 arrives, then out_rdata_o={second[15:0], 0x0513}.
  - Required: in_err_i on the second word only gives out_err_o=1 and out_err_plus2_o=1.
- Fill and overflow (NUM_REQS=4).
  - Stimulus: ready=0; 5 pushes, then a 6th.
  - Required: level_o=5, busy_o=4'b1111, 6th push dropped, overflow_o=1 the next cycle.
  - Required: clear_i resets overflow_o and level_o to 0.
- Simultaneous events.
  - Stimulus 1: level 2, push+pop same cycle. Required: level stays 2 and the data order is preserved.
  - Stimulus 2: clear+push. Required: level 0.
  - Stimulus 3: rst_ni low with clear_i. Required: reset wins.
- CompressedEn=0.
  - Stimulus: word 0x0000_4505.
  - Required: out_compressed_o=0 and the PC advances by 4.
